// File: rtl/cpu_debug_pkg.sv
// Shared encodings for the CPU debug console: run states, display slot offsets, slot names.
// Slot offsets are relative to NUM_STAGES so the map follows the pipeline depth.
package cpu_debug_pkg;

   typedef enum logic [1:0] {
      HALT  = 2'd0,
      STEP  = 2'd1,
      RUN   = 2'd2,
      BREAK = 2'd3
   } run_state_t;

   localparam int OFS_IF_IN = 1;
   localparam int OFS_MADDR = 2;
   localparam int OFS_MDATA = 3;
   localparam int OFS_BKPT  = 4;
   localparam int OFS_CYCLE = 5;
   localparam int OFS_STATE = 6;

   localparam logic [39:0] NAME_IF_IN = "IF_IN";
   localparam logic [39:0] NAME_MADDR = "MADDR";
   localparam logic [39:0] NAME_MDATA = "MDATA";
   localparam logic [39:0] NAME_BKPT  = "BKPT ";
   localparam logic [39:0] NAME_CYCLE = "CYCLE";
   localparam logic [39:0] NAME_STATE = "STATE";

   localparam logic [7:0] ASCII_0 = 8'h30;

   // Two ASCII decimal digits for a register index 0..31.
   function automatic logic [15:0] dec2(input logic [4:0] v);
      logic [4:0] tens;
      logic [4:0] ones;
      tens = v / 5'd10;
      ones = v % 5'd10;
      return {ASCII_0 + {3'b000, tens}, ASCII_0 + {3'b000, ones}};
   endfunction

endpackage

// File: rtl/cpu_debug_console_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, consecutive-cycle debounce, one-cycle rising-edge event.
// Event appears 2 + DEBOUNCE_CYCLES + 1 cycles after the raw press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic evt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic          armed;
   logic [1:0]    fill;
   logic [CW-1:0] cnt;

   // armed stays low until the button has been seen released after reset, so a
   // button held through reset release cannot produce an event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         armed   <= 1'b0;
         fill    <= 2'b00;
         cnt     <= '0;
         evt     <= 1'b0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         fill    <= {fill[0], 1'b1};
         level_d <= level;
         if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
         if (fill[1] && !sync2 && !level)
            armed <= 1'b1;
         evt <= armed & level & ~level_d;
      end
   end

endmodule

// File: rtl/cpu_debug_console.sv
// Debug console between CPU core and LCD: step/run/breakpoint control, cycle counter, display slot server.
// Display outputs follow display_number by one cycle; cpu_clk_en is combinational from the run state.
module cpu_debug_console
   import cpu_debug_pkg::*;
#(
   parameter int NUM_STAGES      = 5,
   parameter int NUM_REGS        = 32,
   parameter int REG_BASE        = 13,
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     btn_step,
   input  logic                     btn_run,
   output logic                     cpu_clk_en,
   output logic [1:0]               run_state,
   output logic                     bp_hit,
   input  logic [NUM_STAGES*32-1:0] stage_pc,
   input  logic [NUM_STAGES-1:0]    stage_valid,
   input  logic [31:0]              if_inst,
   output logic [4:0]               rf_addr,
   input  logic [31:0]              rf_data,
   output logic [31:0]              mem_addr,
   input  logic [31:0]              mem_data,
   input  logic [5:0]               display_number,
   output logic                     display_valid,
   output logic [39:0]              display_name,
   output logic [31:0]              display_value,
   input  logic                     input_valid,
   input  logic                     input_sel,
   input  logic [31:0]              input_value
);

   localparam logic [5:0] SLOT_IF_IN = 6'(NUM_STAGES + OFS_IF_IN);
   localparam logic [5:0] SLOT_MADDR = 6'(NUM_STAGES + OFS_MADDR);
   localparam logic [5:0] SLOT_MDATA = 6'(NUM_STAGES + OFS_MDATA);
   localparam logic [5:0] SLOT_BKPT  = 6'(NUM_STAGES + OFS_BKPT);
   localparam logic [5:0] SLOT_CYCLE = 6'(NUM_STAGES + OFS_CYCLE);
   localparam logic [5:0] SLOT_STATE = 6'(NUM_STAGES + OFS_STATE);
   localparam logic [5:0] REG_LO     = 6'(REG_BASE);
   localparam logic [5:0] REG_HI     = 6'(REG_BASE + NUM_REGS - 1);

   run_state_t  state;
   run_state_t  state_nx;
   logic        step_evt;
   logic        run_evt;
   logic        skip;
   logic        bp_en;
   logic        bp_match;
   logic [31:0] bp_addr;
   logic [31:0] cycle_cnt;
   logic [7:0]  valid8;
   logic        slot_vld;
   logic [39:0] slot_name;
   logic [31:0] slot_val;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_step),
      .evt   (step_evt)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_run),
      .evt   (run_evt)
   );

   assign bp_match  = bp_en & stage_valid[0] & (stage_pc[31:0] == bp_addr) & ~skip;
   assign run_state = state;
   assign bp_hit    = (state == BREAK);

   // run_evt is tested first everywhere so it wins over a simultaneous step_evt.
   always_comb begin
      state_nx   = state;
      cpu_clk_en = 1'b0;
      case (state)
         HALT: begin
            if (run_evt)       state_nx = RUN;
            else if (step_evt) state_nx = STEP;
         end
         STEP: begin
            cpu_clk_en = 1'b1;
            state_nx   = HALT;
         end
         RUN: begin
            cpu_clk_en = ~bp_match;
            if (run_evt)       state_nx = HALT;
            else if (bp_match) state_nx = BREAK;
         end
         BREAK: begin
            if (run_evt)       state_nx = RUN;
            else if (step_evt) state_nx = STEP;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HALT;
         skip      <= 1'b0;
         cycle_cnt <= '0;
         mem_addr  <= '0;
         bp_addr   <= '0;
         bp_en     <= 1'b0;
      end else begin
         state <= state_nx;
         // skip covers only the first RUN cycle after leaving BREAK.
         if (state == BREAK && state_nx == RUN)
            skip <= 1'b1;
         else if (state == RUN)
            skip <= 1'b0;
         if (cpu_clk_en)
            cycle_cnt <= cycle_cnt + 32'd1;
         if (input_valid) begin
            if (input_sel) begin
               bp_addr <= input_value;
               bp_en   <= (input_value != 32'hFFFF_FFFF);
            end else begin
               mem_addr <= input_value;
            end
         end
      end
   end

   assign rf_addr = 5'(display_number - REG_LO);
   assign valid8  = 8'(stage_valid);

   always_comb begin
      slot_vld  = 1'b0;
      slot_name = '0;
      slot_val  = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (display_number == 6'(i + 1)) begin
            slot_vld  = 1'b1;
            slot_name = {"S", 8'(32'h30 + i), "_PC"};
            slot_val  = stage_pc[32*i +: 32];
         end
      end
      if (display_number == SLOT_IF_IN) begin
         slot_vld  = 1'b1;
         slot_name = NAME_IF_IN;
         slot_val  = if_inst;
      end else if (display_number == SLOT_MADDR) begin
         slot_vld  = 1'b1;
         slot_name = NAME_MADDR;
         slot_val  = mem_addr;
      end else if (display_number == SLOT_MDATA) begin
         slot_vld  = 1'b1;
         slot_name = NAME_MDATA;
         slot_val  = mem_data;
      end else if (display_number == SLOT_BKPT) begin
         slot_vld  = 1'b1;
         slot_name = NAME_BKPT;
         slot_val  = bp_addr;
      end else if (display_number == SLOT_CYCLE) begin
         slot_vld  = 1'b1;
         slot_name = NAME_CYCLE;
         slot_val  = cycle_cnt;
      end else if (display_number == SLOT_STATE) begin
         slot_vld  = 1'b1;
         slot_name = NAME_STATE;
         slot_val  = {bp_en, 21'b0, state, valid8};
      end else if (display_number >= REG_LO && display_number <= REG_HI) begin
         slot_vld  = 1'b1;
         slot_name = {"REG", dec2(rf_addr)};
         slot_val  = rf_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         display_valid <= 1'b0;
         display_name  <= '0;
         display_value <= '0;
      end else begin
         display_valid <= slot_vld;
         display_name  <= slot_name;
         display_value <= slot_val;
      end
   end

endmodule

// File: tb/tb_cpu_debug_console.sv
// Self-checking bench for cpu_debug_console: button/FSM sequences, breakpoint, display slot map, reset and wrap.
module tb_cpu_debug_console;

   localparam int NS = 5;
   localparam int NR = 32;
   localparam int RB = 13;
   localparam int DB = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           btn_step, btn_run;
   logic           cpu_clk_en, bp_hit;
   logic [1:0]     run_state;
   logic [NS*32-1:0] stage_pc;
   logic [NS-1:0]  stage_valid;
   logic [31:0]    if_inst, rf_data, mem_addr, mem_data, display_value, input_value;
   logic [4:0]     rf_addr;
   logic [5:0]     display_number;
   logic           display_valid, input_valid, input_sel;
   logic [39:0]    display_name;

   cpu_debug_console #(
      .NUM_STAGES(NS), .NUM_REGS(NR), .REG_BASE(RB), .DEBOUNCE_CYCLES(DB)
   ) u_dut (
      .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run),
      .cpu_clk_en(cpu_clk_en), .run_state(run_state), .bp_hit(bp_hit),
      .stage_pc(stage_pc), .stage_valid(stage_valid), .if_inst(if_inst),
      .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
      .display_number(display_number), .display_valid(display_valid),
      .display_name(display_name), .display_value(display_value),
      .input_valid(input_valid), .input_sel(input_sel), .input_value(input_value)
   );

   always #5 clk = ~clk;

   // Simple CPU: IF PC advances by 4 on every enabled cycle.
   logic [31:0] pc = '0;
   logic [31:0] pc_ld_val = '0;
   logic        pc_ld = 1'b0;
   logic [31:0] spc [1:NS-1];
   logic [31:0] rf [0:31];

   always @(posedge clk)
      if (pc_ld) pc <= pc_ld_val;
      else if (cpu_clk_en) pc <= pc + 32'd4;

   always_comb begin
      stage_pc[31:0] = pc;
      for (int i = 1; i < NS; i++) stage_pc[32*i +: 32] = spc[i];
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   assign rf_data  = rf[rf_addr];
   assign mem_data = memf(mem_addr);

   int en_cnt = 0;
   int step_seen = 0;
   always @(negedge clk) begin
      if (cpu_clk_en) en_cnt++;
      if (run_state == 2'd1) step_seen++;
   end

   // Reference state derived from the stimulus applied.
   logic [31:0] mem_m = '0, bp_m = '0, cyc_base = '0;
   logic        bpen_m = 1'b0;
   int          en_mark = 0;
   int          total = 0, passed = 0;

   function automatic logic [31:0] cyc_exp();
      return cyc_base + 32'(en_cnt - en_mark);
   endfunction

   task automatic set_cyc_base(input logic [31:0] v);
      cyc_base = v;
      en_mark  = en_cnt;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic chk_s(input string nm, input string act, input string exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got '%s', expected '%s'", nm, act, exp);
   endtask

   task automatic press(input bit s, input bit r);
      @(posedge clk); #1;
      btn_step = s; btn_run = r;
      repeat (10) @(posedge clk);
      #1;
      btn_step = 1'b0; btn_run = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic set_pc(input logic [31:0] v);
      @(posedge clk); #1;
      pc_ld = 1'b1; pc_ld_val = v;
      @(posedge clk); #1;
      pc_ld = 1'b0;
   endtask

   task automatic enter(input bit sel, input logic [31:0] v);
      @(posedge clk); #1;
      input_valid = 1'b1; input_sel = sel; input_value = v;
      @(posedge clk); #1;
      input_valid = 1'b0; input_value = $urandom;
      if (sel) begin
         bp_m = v; bpen_m = (v != 32'hFFFF_FFFF);
      end else begin
         mem_m = v;
         chk("mem_addr after entry", {32'b0, mem_addr}, {32'b0, v});
      end
   endtask

   task automatic read_slot(input int n, output logic v, output logic [39:0] nm, output logic [31:0] val);
      @(posedge clk); #1;
      display_number = 6'(n);
      @(posedge clk); #1;
      v = display_valid; nm = display_name; val = display_value;
   endtask

   // Expected slot contents from the slot-map rules; only used while halted.
   function automatic void model_slot(input int n, output bit v, output string nm, output logic [31:0] val);
      v = 1'b1; nm = ""; val = '0;
      if (n >= 1 && n <= NS) begin
         nm = $sformatf("S%0d_PC", n - 1);
         val = (n == 1) ? pc : spc[n-1];
      end else if (n == NS + 1) begin nm = "IF_IN"; val = if_inst;
      end else if (n == NS + 2) begin nm = "MADDR"; val = mem_m;
      end else if (n == NS + 3) begin nm = "MDATA"; val = memf(mem_m);
      end else if (n == NS + 4) begin nm = "BKPT "; val = bp_m;
      end else if (n == NS + 5) begin nm = "CYCLE"; val = cyc_exp();
      end else if (n == NS + 6) begin nm = "STATE"; val = {bpen_m, 21'b0, 2'b00, 3'b000, stage_valid};
      end else if (n >= RB && n < RB + NR) begin
         nm = $sformatf("REG%02d", n - RB);
         val = rf[n-RB];
      end else v = 1'b0;
   endfunction

   task automatic check_slot(input int n);
      logic v; logic [39:0] nm; logic [31:0] val;
      bit ev; string enm; logic [31:0] evl;
      read_slot(n, v, nm, val);
      model_slot(n, ev, enm, evl);
      chk($sformatf("slot%0d valid", n), {63'b0, v}, {63'b0, ev});
      if (ev) begin
         chk_s($sformatf("slot%0d name", n), $sformatf("%s", nm), enm);
         chk($sformatf("slot%0d value", n), {32'b0, val}, {32'b0, evl});
      end else begin
         chk($sformatf("slot%0d name", n), {24'b0, nm}, 64'd0);
         chk($sformatf("slot%0d value", n), {32'b0, val}, 64'd0);
      end
   endtask

   typedef struct {
      int          n;
      bit          v;
      string       name;
      logic [31:0] value;
      logic [4:0]  rf;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic v; logic [39:0] nm; logic [31:0] val;
      int lat, e0, s0;

      reset = 1'b1; btn_step = 1'b0; btn_run = 1'b0;
      input_valid = 1'b0; input_sel = 1'b0; input_value = '0;
      display_number = '0; stage_valid = 5'b00001; if_inst = 32'h0000_0013;
      for (int i = 1; i < NS; i++) spc[i] = 32'h1000 * i;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;

      repeat (3) @(posedge clk);
      #1;
      chk("reset cpu_clk_en", {63'b0, cpu_clk_en}, 64'd0);
      chk("reset run_state", {62'b0, run_state}, 64'd0);
      chk("reset bp_hit", {63'b0, bp_hit}, 64'd0);
      chk("reset display_valid", {63'b0, display_valid}, 64'd0);
      chk("reset display_name", {24'b0, display_name}, 64'd0);
      chk("reset mem_addr", {32'b0, mem_addr}, 64'd0);
      @(negedge clk) reset = 1'b0;
      repeat (4) @(posedge clk);

      // Glitch shorter than the debounce window must not step the CPU.
      e0 = en_cnt;
      @(posedge clk); #1 btn_step = 1'b1;
      repeat (3) @(posedge clk);
      #1 btn_step = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("glitch enables", 64'(en_cnt - e0), 64'd0);

      // Clean press: latency 2 + DB + 1 + 1 to the single enable pulse.
      e0 = en_cnt; lat = 0;
      @(posedge clk); #1 btn_step = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk); #1;
         if (cpu_clk_en && lat == 0) lat = k;
         if (k == 10) btn_step = 1'b0;
      end
      chk("step latency", 64'(lat), 64'(2 + DB + 2));
      chk("step enables", 64'(en_cnt - e0), 64'd1);
      chk("step run_state", {62'b0, run_state}, 64'd0);
      read_slot(NS + 5, v, nm, val);
      chk("cycle after step", {32'b0, val}, 64'd1);

      // Breakpoint at 0x10 stops with the breakpoint PC still in IF.
      enter(1'b1, 32'h0000_0010);
      set_pc(32'h0);
      e0 = en_cnt;
      press(1'b0, 1'b1);
      chk("bp run_state", {62'b0, run_state}, 64'd3);
      chk("bp bp_hit", {63'b0, bp_hit}, 64'd1);
      chk("bp cpu_clk_en", {63'b0, cpu_clk_en}, 64'd0);
      chk("bp pc", {32'b0, pc}, 64'h10);
      chk("bp enables", 64'(en_cnt - e0), 64'd4);
      read_slot(NS + 5, v, nm, val);
      chk("cycle at break", {32'b0, val}, 64'd5);

      // Resume must step past the breakpoint instead of rematching it.
      press(1'b0, 1'b1);
      chk("resume run_state", {62'b0, run_state}, 64'd2);
      chk("resume passed bp", {63'b0, (pc > 32'h14)}, 64'd1);
      press(1'b0, 1'b1);
      chk("halt run_state", {62'b0, run_state}, 64'd0);
      chk("halt cpu_clk_en", {63'b0, cpu_clk_en}, 64'd0);

      // All-ones entry disables the breakpoint, even at PC FFFF_FFFF.
      enter(1'b1, 32'hFFFF_FFFF);
      check_slot(NS + 6);
      set_pc(32'hFFFF_FFF3);
      press(1'b0, 1'b1);
      chk("nobp run_state", {62'b0, run_state}, 64'd2);
      chk("nobp pc wrapped", {63'b0, (pc < 32'h100)}, 64'd1);
      press(1'b0, 1'b1);
      s0 = step_seen;
      press(1'b1, 1'b1);
      chk("both run_state", {62'b0, run_state}, 64'd2);
      chk("both no step", 64'(step_seen - s0), 64'd0);
      press(1'b0, 1'b1);
      chk("both halt", {62'b0, run_state}, 64'd0);

      // Fixed display table, including rf_addr wraparound outside the register range.
      enter(1'b0, 32'h0000_0040);
      spc[2] = 32'h0000_2208;
      tbl[0] = '{0,  1'b0, "",      32'h0,          5'd19};
      tbl[1] = '{3,  1'b1, "S2_PC", 32'h0000_2208,  5'd22};
      tbl[2] = '{7,  1'b1, "MADDR", 32'h0000_0040,  5'd26};
      tbl[3] = '{12, 1'b0, "",      32'h0,          5'd31};
      tbl[4] = '{13, 1'b1, "REG00", 32'h1000_0000,  5'd0};
      tbl[5] = '{44, 1'b1, "REG31", 32'h1000_001F,  5'd31};
      tbl[6] = '{45, 1'b0, "",      32'h0,          5'd0};
      tbl[7] = '{63, 1'b0, "",      32'h0,          5'd18};
      for (int t = 0; t < 8; t++) begin
         read_slot(tbl[t].n, v, nm, val);
         chk($sformatf("tbl%0d valid", tbl[t].n), {63'b0, v}, {63'b0, tbl[t].v});
         chk($sformatf("tbl%0d rf_addr", tbl[t].n), {59'b0, rf_addr}, {59'b0, tbl[t].rf});
         chk($sformatf("tbl%0d value", tbl[t].n), {32'b0, val}, {32'b0, tbl[t].value});
         if (tbl[t].v) chk_s($sformatf("tbl%0d name", tbl[t].n), $sformatf("%s", nm), tbl[t].name);
         else          chk($sformatf("tbl%0d name", tbl[t].n), {24'b0, nm}, 64'd0);
      end

      // Randomised full sweeps against the slot model.
      for (int r = 0; r < 3; r++) begin
         if_inst = $urandom;
         stage_valid = 5'($urandom);
         for (int i = 1; i < NS; i++) spc[i] = $urandom;
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         enter(1'b0, $urandom);
         enter(1'b1, (r == 1) ? 32'hFFFF_FFFF : 32'($urandom));
         set_pc($urandom);
         for (int n = 0; n < 64; n++) check_slot(n);
      end

      // Asynchronous reset in RUN with the counter at all ones.
      enter(1'b1, 32'hFFFF_FFFF);
      stage_valid = 5'b11111;
      press(1'b0, 1'b1);
      chk("pre-reset run_state", {62'b0, run_state}, 64'd2);
      @(negedge clk);
      force u_dut.cycle_cnt = 32'hFFFF_FFFF;
      #1 release u_dut.cycle_cnt;
      #1 reset = 1'b1;
      #1;
      chk("arst cpu_clk_en", {63'b0, cpu_clk_en}, 64'd0);
      chk("arst run_state", {62'b0, run_state}, 64'd0);
      chk("arst bp_hit", {63'b0, bp_hit}, 64'd0);
      chk("arst display_valid", {63'b0, display_valid}, 64'd0);
      chk("arst display_value", {32'b0, display_value}, 64'd0);
      chk("arst mem_addr", {32'b0, mem_addr}, 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      mem_m = '0; bp_m = '0; bpen_m = 1'b0;
      set_cyc_base(32'h0);
      check_slot(NS + 5);
      check_slot(NS + 4);
      check_slot(NS + 6);

      // Counter wrap from all ones to zero on a single step.
      @(negedge clk);
      force u_dut.cycle_cnt = 32'hFFFF_FFFF;
      #1 release u_dut.cycle_cnt;
      set_cyc_base(32'hFFFF_FFFF);
      check_slot(NS + 5);
      press(1'b1, 1'b0);
      read_slot(NS + 5, v, nm, val);
      chk("cycle wrap", {32'b0, val}, 64'd0);
      check_slot(NS + 5);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
